uart_tx: RTL



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_baud_cnt.sv | 44 ++++
 rtl/uart_tx.sv | 136 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART transmitter/receiver pair.
package uart_pkg;

   localparam int unsigned UART_DATA_W   = 8;
   localparam int unsigned BAUD_9600_50M = 5208;
   localparam int unsigned BAUD_SIM      = 4;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data,
                                       input int unsigned            mode);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request handshake between a byte source and the UART transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] tx_data;
   logic                   pi_flag;
   logic                   tx_ready;
   logic                   tx_done;

   modport master (output tx_data, output pi_flag, input tx_ready, input tx_done);
   modport slave  (input tx_data, input pi_flag, output tx_ready, output tx_done);

endinterface

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: runs 0..BAUD_CNT-1 while enabled, held at 0 otherwise,
// with a registered one-cycle bit_end pulse while the count sits at PULSE_AT.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_CNT = BAUD_9600_50M,
   parameter int unsigned PULSE_AT = BAUD_CNT - 1
) (
   input  logic sclk,
   input  logic srst,
   input  logic en,
   output logic bit_end
);

   localparam int unsigned CNT_W = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_HIT  = CNT_W'(PULSE_AT);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             bit_end_d, bit_end_q;

   // The pulse is registered from the next count, so it lines up with cnt_q == PULSE_AT.
   always_comb begin
      cnt_d     = '0;
      bit_end_d = 1'b0;
      if (en) begin
         cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         bit_end_d = (cnt_d == CNT_HIT);
      end
   end

   always_ff @(posedge sclk) begin
      if (!srst) begin
         cnt_q     <= '0;
         bit_end_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_end_q <= bit_end_d;
      end
   end

   assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_CNT  = BAUD_9600_50M,
   parameter int unsigned PARITY    = PARITY_NONE,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic      sclk,
   input  logic      srst,
   uart_tx_if.slave  bus,
   output logic      tx
);

   localparam int unsigned BIT_CNT_W = 3;

   if (BAUD_CNT < 2) begin : g_bad_baud
      $error("uart_tx: BAUD_CNT must be at least 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end

   tx_state_e              state_d, state_q;
   logic [UART_DATA_W-1:0] shift_d, shift_q;
   logic                   parity_d, parity_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_d, bit_cnt_q;
   logic                   tx_d, tx_q;
   logic                   ready_d, ready_q;
   logic                   done_d, done_q;
   logic                   baud_en;
   logic                   bit_end;

   assign baud_en = (state_q != ST_IDLE);

   uart_baud_cnt #(
      .BAUD_CNT (BAUD_CNT)
   ) u_baud (
      .sclk    (sclk),
      .srst    (srst),
      .en      (baud_en),
      .bit_end (bit_end)
   );

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.pi_flag && ready_q) begin
               shift_d  = bus.tx_data;
               parity_d = parity_bit(bus.tx_data, PARITY);
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BIT_CNT_W'(UART_DATA_W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);

      // Line level follows the current state, so tx trails the state by one register.
      unique case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[0];
         ST_PARITY: tx_d = parity_q;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!srst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign tx           = tx_q;
   assign bus.tx_ready = ready_q;
   assign bus.tx_done  = done_q;

endmodule
